mem_byte_writer: RTL
====================

# mem_byte_writer

Store-path serializer for the byte-wide data memory port. It accepts one store request (address, 32-bit data, size) from the memory stage and emits it as 1, 2 or 4 consecutive single-byte writes, least-significant byte first, at ascending addresses. It is the write-side counterpart of the instruction-byte assembler in the fetch path: that block collects four bytes into a word, and this one splits a word into bytes. It sits between the MEM stage and the shared memory bus. While it is busy it holds the pipeline through `stall_req`.

## Interface
- `ADDR_W`, default 32: width of the store address and of the memory address bus.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous reset, active-low.
- `st_req` in 1: store request, sampled only when `st_ready`=1.
- `st_addr` in ADDR_W: byte address of the first (least-significant) byte.
- `st_data` in 32: store data, little-endian.
- `st_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `st_ready` out 1: block is idle and will accept `st_req` this cycle.
- `st_done` out 1: one-cycle pulse, coincident with the last byte beat.
- `stall_req` out 1: high from the acceptance cycle through the last beat.
- `mem_we` out 1: byte write strobe.
- `mem_addr` out ADDR_W: byte write address, valid when `mem_we`=1, else 0.
- `mem_dout` out 8: byte write data, valid when `mem_we`=1, else 0.

## Operation
- States:
  - IDLE: `st_ready`=1.
  - WRITE: beats in progress.
- Internal registers:
  - latched base address and data.
  - 2-bit beat index `idx`.
  - 2-bit `last` = number of bytes − 1 (0, 1 or 3).
- IDLE → WRITE when `st_req`=1 at a rising edge. On that edge, latch `st_addr`, `st_data` and `last`, and set `idx`=0.
- In WRITE, one beat per cycle:
  - `mem_we`=1.
  - `mem_addr` = base + `idx`, modulo 2^ADDR_W (wraps at all-ones; no alignment check, misaligned stores allowed).
  - `mem_dout` = `data[8*idx +: 8]`.
- When `idx` == `last`, assert `st_done` in that same beat and return to IDLE at the next edge. Otherwise `idx` increments.
- All outputs are registered.
- `st_req` while not ready is ignored. It is neither queued nor latched.
- Input changes after acceptance have no effect; the latched copy is used.
- Reset values (`rst`=0 at an edge):
  - state IDLE.
  - `st_ready`=0, `st_done`=0, `stall_req`=0, `mem_we`=0, `mem_addr`=0, `mem_dout`=0.
  - `idx`=0.
  - `st_ready` rises to 1 on the first edge with `rst`=1.
- Reset mid-operation aborts the store. The next edge has `mem_we`=0, no further beats are issued, and no `st_done` is produced.

## Timing
- Acceptance edge E0: `st_req`=1 and `st_ready`=1. After E0:
  - `st_ready`=0.
  - `stall_req`=1.
  - first beat valid (`mem_we`=1, idx 0).
- Beat k (0-based) is valid in the cycle after edge E0+k.
- Last beat:
  - byte: after E0.
  - half: after E0+1.
  - word: after E0+3.
- `st_done`=1 only during the last beat.
- At the edge ending the last beat: `st_ready`=1, `stall_req`=0, `mem_we`=0.
- Latency from request to `st_ready`:
  - byte: 2 edges.
  - half: 3 edges.
  - word: 5 edges.
- Back-to-back: a new request can be accepted on the first edge where `st_ready`=1. This leaves exactly one idle bus cycle between stores.
- Simultaneous `rst`=0 and `st_req`=1: reset wins and the request is dropped.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `st_req`=1 → all outputs 0, no `mem_we`. Release reset → `st_ready`=1 after the first edge.
- Word store, addr 0x00001000, data 0xDEADBEEF, size 10 → beats (0x1000, 0xEF), (0x1001, 0xBE), (0x1002, 0xAD), (0x1003, 0xDE) on consecutive cycles. `st_done` on the 4th beat only. `stall_req` high for exactly 4 cycles.
- Byte store, addr 0x00000007, data 0x12345678, size 00 → single beat (0x7, 0x78) with `st_done`. Half store, addr 0x00000003, data 0x0000A1B2, size 01 → (0x3, 0xB2), (0x4, 0xA1).
- Wrap and size 11: addr 0xFFFFFFFE, size 11, data 0x44332211 → beats at 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001 with bytes 11, 22, 33, 44.
- Busy-ignore and back-to-back:
  - Pulse `st_req` with new data during beat 2 of a word store → ignored; the bus shows original bytes only.
  - Second request presented the cycle `st_ready` returns → accepted, with one idle cycle between the stores.
- Reset mid-store: assert `rst`=0 during beat 1 of a word store → `mem_we`=0 on the next cycle, no `st_done`. After release, a fresh byte store completes normally.

Source files
------------

// File: rtl/mem_byte_writer_if.sv
// Store request / byte-wide memory write bundle between the MEM stage and the
// store serializer. The slave side is the serializer itself.
interface mem_byte_writer_if #(
    parameter int ADDR_W = 32
);
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;
    logic              st_ready;
    logic              st_done;
    logic              stall_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_dout;

    modport master (
        output st_req, st_addr, st_data, st_size,
        input  st_ready, st_done, stall_req, mem_we, mem_addr, mem_dout
    );

    modport slave (
        input  st_req, st_addr, st_data, st_size,
        output st_ready, st_done, stall_req, mem_we, mem_addr, mem_dout
    );
endinterface

// File: rtl/mem_byte_writer.sv
// Store-path serializer: splits one 8/16/32-bit store into single-byte writes,
// least-significant byte first at ascending (wrapping) addresses.
module mem_byte_writer #(
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_byte_writer_if.slave bus
);
    typedef enum logic {IDLE, WRITE} state_t;

    typedef struct packed {
        logic              ready;
        logic              stall;
        logic              done;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        dout;
    } out_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] base_q, base_n;
    logic [3:0][7:0]   data_q, data_n;
    logic [1:0]        idx_q, idx_n;
    logic [1:0]        last_q, last_n;
    out_t              out_q, out_n;

    function automatic logic [1:0] size_to_last(input logic [1:0] size);
        case (size)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Output image of a single beat; addresses wrap modulo 2^ADDR_W.
    function automatic out_t beat_out(input logic [ADDR_W-1:0] base,
                                      input logic [3:0][7:0]   data,
                                      input logic [1:0]        idx,
                                      input logic [1:0]        last);
        out_t o;
        o       = '0;
        o.stall = 1'b1;
        o.we    = 1'b1;
        o.done  = (idx == last);
        o.addr  = base + {{(ADDR_W-2){1'b0}}, idx};
        o.dout  = data[idx];
        return o;
    endfunction

    // Outputs are computed one cycle ahead so every port comes from a flop.
    always_comb begin
        state_n = state_q;
        base_n  = base_q;
        data_n  = data_q;
        idx_n   = idx_q;
        last_n  = last_q;
        out_n   = '0;
        case (state_q)
            IDLE: begin
                out_n.ready = 1'b1;
                if (bus.st_req && out_q.ready) begin
                    state_n = WRITE;
                    base_n  = bus.st_addr;
                    data_n  = bus.st_data;
                    last_n  = size_to_last(bus.st_size);
                    idx_n   = 2'd0;
                    out_n   = beat_out(bus.st_addr, bus.st_data, 2'd0,
                                       size_to_last(bus.st_size));
                end
            end
            WRITE: begin
                if (idx_q == last_q) begin
                    state_n     = IDLE;
                    idx_n       = 2'd0;
                    out_n.ready = 1'b1;
                end else begin
                    idx_n = idx_q + 2'd1;
                    out_n = beat_out(base_q, data_q, idx_q + 2'd1, last_q);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            data_q  <= '0;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            out_q   <= '0;
        end else begin
            state_q <= state_n;
            base_q  <= base_n;
            data_q  <= data_n;
            idx_q   <= idx_n;
            last_q  <= last_n;
            out_q   <= out_n;
        end
    end

    assign bus.st_ready  = out_q.ready;
    assign bus.stall_req = out_q.stall;
    assign bus.st_done   = out_q.done;
    assign bus.mem_we    = out_q.we;
    assign bus.mem_addr  = out_q.addr;
    assign bus.mem_dout  = out_q.dout;
endmodule
